// File: rtl/fifo_pkg.sv
// Shared types and helpers for the parametrised FIFO.
// Used by the RTL, the assertion bench and the scoreboard.
package fifo_pkg;

  typedef struct packed {
    logic wr_ack;
    logic overflow;
    logic underflow;
  } flags_t;

  function automatic int calc_cw(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_wrap_ptr.sv
// Circular FIFO pointer that wraps by explicit compare,
// so depths that are not a power of two work.
module fifo_wrap_ptr #(
  parameter int DEPTH = 8,
  localparam int PW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          inc,
  output logic [PW-1:0] ptr
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (flush) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
    end
  end

endmodule

// File: rtl/param_fifo.sv
// Single-clock FIFO with registered handshake flags,
// occupancy count, almost-full/empty levels and flush.
module param_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int AE_LEVEL = 1,
  localparam int CW = calc_cw(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  wr_ack,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  full,
  output logic                  empty,
  output logic                  almostfull,
  output logic                  almostempty,
  output logic [CW-1:0]         count
);

  localparam int PW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic wr_ok;
  logic rd_ok;
  flags_t flg;

  assign full        = (count == CW'(DEPTH));
  assign empty       = (count == '0);
  assign almostfull  = (count >= CW'(AF_LEVEL));
  assign almostempty = (count <= CW'(AE_LEVEL));

  // A read in the same edge frees the slot a full FIFO needs.
  assign wr_ok = !flush && wr_en && (!full || rd_en);
  assign rd_ok = !flush && rd_en && !empty;

  fifo_wrap_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .inc   (wr_ok),
    .ptr   (wr_ptr)
  );

  fifo_wrap_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .inc   (rd_ok),
    .ptr   (rd_ptr)
  );

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out <= '0;
    end else if (rd_ok) begin
      data_out <= mem[rd_ptr];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (flush) begin
      count <= '0;
    end else begin
      unique case ({wr_ok, rd_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flg <= '0;
    end else if (flush) begin
      flg <= '0;
    end else begin
      flg.wr_ack    <= wr_ok;
      flg.overflow  <= wr_en && !wr_ok;
      flg.underflow <= rd_en && !rd_ok;
    end
  end

  assign wr_ack    = flg.wr_ack;
  assign overflow  = flg.overflow;
  assign underflow = flg.underflow;

endmodule

// File: tb/tb_param_fifo.sv
// Randomised self-checking bench for param_fifo against
// a queue-based reference model (DEPTH=8 and DEPTH=6).
module tb_param_fifo;

  logic clk = 1'b0;
  logic rst;
  logic [1:0] wr, rd, fl;
  logic [15:0] din [2];

  logic [15:0] dout [2];
  logic [1:0] ack, ovf, unf, full, empty, af, ae;
  logic [3:0] cnt0;
  logic [2:0] cnt1;
  logic [26:0] obs [2];

  int vec = 0;
  int errs = 0;

  logic [15:0] q [2][$];
  logic [15:0] e_do [2];
  bit e_ack [2];
  bit e_ovf [2];
  bit e_unf [2];
  int dep [2] = '{8, 6};
  int afl [2] = '{6, 5};
  int ael [2] = '{2, 1};

  always #5 clk = ~clk;

  param_fifo #(
    .DATA_WIDTH (16),
    .DEPTH      (8),
    .AF_LEVEL   (6),
    .AE_LEVEL   (2)
  ) u8 (
    .clk         (clk),
    .rst         (rst),
    .flush       (fl[0]),
    .wr_en       (wr[0]),
    .data_in     (din[0]),
    .rd_en       (rd[0]),
    .data_out    (dout[0]),
    .wr_ack      (ack[0]),
    .overflow    (ovf[0]),
    .underflow   (unf[0]),
    .full        (full[0]),
    .empty       (empty[0]),
    .almostfull  (af[0]),
    .almostempty (ae[0]),
    .count       (cnt0)
  );

  param_fifo #(
    .DATA_WIDTH (16),
    .DEPTH      (6)
  ) u6 (
    .clk         (clk),
    .rst         (rst),
    .flush       (fl[1]),
    .wr_en       (wr[1]),
    .data_in     (din[1]),
    .rd_en       (rd[1]),
    .data_out    (dout[1]),
    .wr_ack      (ack[1]),
    .overflow    (ovf[1]),
    .underflow   (unf[1]),
    .full        (full[1]),
    .empty       (empty[1]),
    .almostfull  (af[1]),
    .almostempty (ae[1]),
    .count       (cnt1)
  );

  assign obs[0] = {dout[0], ack[0], ovf[0], unf[0], full[0],
                   empty[0], af[0], ae[0], cnt0};
  assign obs[1] = {dout[1], ack[1], ovf[1], unf[1], full[1],
                   empty[1], af[1], ae[1], 1'b0, cnt1};

  function automatic logic [26:0] expv(int k);
    int n = q[k].size();
    return {e_do[k], e_ack[k], e_ovf[k], e_unf[k],
            n == dep[k], n == 0, n >= afl[k], n <= ael[k],
            4'(n)};
  endfunction

  task automatic mreset();
    for (int k = 0; k < 2; k++) begin
      q[k].delete();
      e_do[k] = '0;
      e_ack[k] = 0;
      e_ovf[k] = 0;
      e_unf[k] = 0;
    end
  endtask

  task automatic mstep(int k);
    int n = q[k].size();
    bit wa, ra;
    if (fl[k]) begin
      q[k].delete();
      e_ack[k] = 0;
      e_ovf[k] = 0;
      e_unf[k] = 0;
      return;
    end
    wa = wr[k] && (n < dep[k] || rd[k]);
    ra = rd[k] && n > 0;
    if (ra) e_do[k] = q[k].pop_front();
    if (wa) q[k].push_back(din[k]);
    e_ack[k] = wa;
    e_ovf[k] = wr[k] && !wa;
    e_unf[k] = rd[k] && !ra;
  endtask

  task automatic cyc(int k, bit w, bit r, logic [15:0] d, bit f);
    wr = '0;
    rd = '0;
    fl = '0;
    wr[k] = w;
    rd[k] = r;
    fl[k] = f;
    din[k] = d;
    @(posedge clk);
    mstep(0);
    mstep(1);
    #1;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 2; k++) begin
      vec++;
      if (obs[k] !== expv(k)) begin
        errs++;
        $display("FAIL reset_init[%0d]: got %h exp %h", k, obs[k], expv(k));
      end
    end
    rst = 1'b0;
    for (int i = 0; i < 5; i++) cyc(0, 1, 0, 16'($urandom), 0);
    cyc(0, 1, 1, 16'($urandom), 0);
    vec++;
    if (obs[0] !== expv(0)) begin
      errs++;
      $display("FAIL pre_rst: got %h exp %h", obs[0], expv(0));
    end
    #2 rst = 1'b1;
    #1;
    vec++;
    if ({dout[0], ack[0], empty[0], cnt0} !== {16'h0, 1'b0, 1'b1, 4'h0}) begin
      errs++;
      $display("FAIL async_rst: got %h/%b/%b/%0d exp 0/0/1/0",
               dout[0], ack[0], empty[0], cnt0);
    end
    mreset();
    @(posedge clk);
    #1 rst = 1'b0;
    vec++;
    if (obs[0] !== expv(0)) begin
      errs++;
      $display("FAIL post_rst: got %h exp %h", obs[0], expv(0));
    end
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 9; i++) begin
      cyc(0, 1, 0, 16'(i), 0);
      vec++;
      if (obs[0] !== expv(0)) begin
        errs++;
        $display("FAIL fill[%0d]: got %h exp %h", i, obs[0], expv(0));
      end
    end
  endtask

  task automatic test_drain();
    for (int i = 1; i <= 9; i++) begin
      cyc(0, 0, 1, 16'h0, 0);
      vec++;
      if (obs[0] !== expv(0)) begin
        errs++;
        $display("FAIL drain[%0d]: got %h exp %h", i, obs[0], expv(0));
      end
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 20; i++) begin
      cyc(1, 1, 1'($urandom_range(0, 1)), 16'($urandom), 0);
      vec++;
      if (obs[1] !== expv(1) || cnt1 > 3'd6) begin
        errs++;
        $display("FAIL wrap_w[%0d]: got %h exp %h", i, obs[1], expv(1));
      end
      cyc(1, 1'($urandom_range(0, 1)), 1, 16'($urandom), 0);
      vec++;
      if (obs[1] !== expv(1) || cnt1 > 3'd6) begin
        errs++;
        $display("FAIL wrap_r[%0d]: got %h exp %h", i, obs[1], expv(1));
      end
    end
  endtask

  task automatic test_simul();
    cyc(0, 1, 1, 16'hBEEF, 0);
    vec++;
    if (obs[0] !== expv(0) || {ack[0], unf[0], cnt0} !== 6'b11_0001) begin
      errs++;
      $display("FAIL simul_empty: got %h exp %h", obs[0], expv(0));
    end
    for (int i = 0; i < 7; i++) cyc(0, 1, 0, 16'($urandom), 0);
    cyc(0, 1, 1, 16'h1234, 0);
    vec++;
    if (obs[0] !== expv(0) || {ack[0], ovf[0], cnt0} !== 6'b10_1000) begin
      errs++;
      $display("FAIL simul_full: got %h exp %h", obs[0], expv(0));
    end
  endtask

  task automatic test_levels();
    cyc(0, 0, 0, 16'h0, 1);
    for (int i = 0; i < 16; i++) begin
      cyc(0, i < 8, i >= 8, 16'($urandom), 0);
      vec++;
      if (obs[0] !== expv(0)) begin
        errs++;
        $display("FAIL levels[%0d]: got %h exp %h", i, obs[0], expv(0));
      end
    end
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, 16'($urandom), 0);
    cyc(0, 1, 1, 16'hAAAA, 1);
    vec++;
    if (obs[0] !== expv(0) || cnt0 !== 4'd0) begin
      errs++;
      $display("FAIL flush: got %h exp %h", obs[0], expv(0));
    end
    cyc(0, 0, 1, 16'h0, 0);
    vec++;
    if (obs[0] !== expv(0)) begin
      errs++;
      $display("FAIL flush_drop: got %h exp %h", obs[0], expv(0));
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      cyc(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          16'($urandom), $urandom_range(0, 31) == 0);
      vec++;
      if (obs[0] !== expv(0)) begin
        errs++;
        $display("FAIL random[%0d]: got %h exp %h", i, obs[0], expv(0));
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    wr = '0;
    rd = '0;
    fl = '0;
    din[0] = '0;
    din[1] = '0;
    mreset();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_fill();
    test_drain();
    test_wrap();
    test_simul();
    test_levels();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
